fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit. Holds the PC and fetches from instruction memory over a req/ack handshake.
- Latches the instruction word into an instruction register and splits it into opcode/funct3/funct7 and register fields for the control unit and register file.
- Computes the next PC from the jump/branch outcome returned by execute (j_sel / jal_sel path).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
XLEN, 32, width of PC, addresses and instruction word

Ports:
clk  in  1  single system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  XLEN  fetch address (equals pc)
imem_ack  in  1  memory has data on imem_rdata; sampled only while imem_req=1
imem_rdata  in  XLEN  instruction word
exec_done  in  1  execute has finished the current instruction; pulse
branch_taken  in  1  conditional branch resolved taken (qualified by jal_sel)
jump  in  1  unconditional jump (j_sel: jal/jalr)
target  in  XLEN  branch/jump target computed by execute
inst_valid  out  1  instr and decoded fields are valid
instr  out  XLEN  instruction register
opcode  out  7  instr[6:0]
funct3  out  3  instr[14:12]
funct7  out  7  instr[31:25]
rd  out  5  instr[11:7]
rs1  out  5  instr[19:15]
rs2  out  5  instr[24:20]
pc  out  XLEN  address of the instruction in instr
pc_plus4  out  XLEN  pc + 4, modulo 2^XLEN (link value for jal/jalr)
misaligned  out  1  sticky; target not 4-byte aligned, fetch halted
instret  out  32  count of completed instructions, wraps at 2^32

Behaviour:
- FSM states: S_BOOT, S_REQ, S_VALID, S_HALT.
- Reset (rst=1 at an edge) overrides all other inputs, including mid-handshake:
  - state=S_BOOT, pc=RESET_PC, instr=32'h0000_0013 (nop).
  - inst_valid=0, imem_req=0, misaligned=0, instret=0.
- S_BOOT: imem_req=0 for exactly one cycle so a stale ack is ignored; then go to S_REQ.
- S_REQ:
  - imem_req=1 and imem_addr=pc, both held stable until ack.
  - On imem_ack=1: instr<=imem_rdata, go to S_VALID.
  - Ack in the same cycle as req is legal (zero-wait memory).
- S_VALID:
  - inst_valid=1, imem_req=0; instr and fields stay stable until exec_done.
  - On exec_done, next PC is:
    - if jump=1 or branch_taken=1: {target[XLEN-1:1],1'b0} (bit 0 cleared for jalr);
    - otherwise pc+4.
  - jump has priority; both high gives the same result.
  - Then instret<=instret+1.
  - If the chosen next PC has bit[1]=1: misaligned<=1, pc unchanged, go to S_HALT.
  - Otherwise pc<=next, go to S_REQ.
- S_HALT: inst_valid=0, imem_req=0; stays here until rst.
- exec_done, branch_taken, jump and target are ignored outside S_VALID.
- imem_ack is ignored outside S_REQ.
- Latency:
  - ack in cycle N -> inst_valid=1 in cycle N+1.
  - exec_done in cycle M -> imem_req=1 with the new address in cycle M+1.
  - Minimum 2 cycles per instruction.
- PC wrap: pc+4 from 32'hFFFF_FFFC gives 32'h0000_0000, with no flag.
- Fields are pure wiring of instr and are valid whenever inst_valid=1.

Decomposition:
- Shared package:
  - FSM state encoding (2 bits).
  - NOP constant 32'h0000_0013.
  - Instruction field bit positions.
  - Opcode constants (R 0110011, I 0010011, LOAD 0000011, S 0100011, B 1100011, JALR 1100111, JAL 1101111, LUI 0110111) shared with the control unit.
- One sub-module, next_pc_sel: combinational mux producing next PC and the misalignment flag from pc, target, jump and branch_taken.

Test Plan:
- Reset then ack with 2-cycle delay, rdata=32'h00500093:
  - imem_addr=0; inst_valid rises the cycle after ack;
  - opcode=0010011, rd=1, rs1=0, funct3=000.
- exec_done with jump=0, branch_taken=0 at pc=0x10: next imem_addr=0x14, instret increments by 1.
- exec_done with branch_taken=1, target=0x40: next fetch at 0x40. Repeat with jump=1, target=0x41 (jalr): next fetch at 0x40.
- exec_done with jump=1, target=0x42: misaligned=1, state S_HALT, imem_req stays 0, pc unchanged.
- rst asserted while in S_REQ awaiting ack; then ack pulses during S_BOOT:
  - ack ignored, instr=nop;
  - the next fetch is at RESET_PC.
- pc=32'hFFFF_FFFC, exec_done with no jump: next imem_addr=0; zero-wait ack gives 2 cycles per instruction back-to-back.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the fetch stage and control unit
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int F3_LSB  = 12;
  localparam int F3_MSB  = 14;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;
  localparam int F7_LSB  = 25;
  localparam int F7_MSB  = 31;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_S    = 7'b0100011;
  localparam logic [6:0] OPC_B    = 7'b1100011;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory req/ack bus between fetch and imem
interface fetch_unit_if #(
  parameter int XLEN = 32
) ();
  logic            req;
  logic [XLEN-1:0] addr;
  logic            ack;
  logic [XLEN-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// rtl/fetch_unit_next_pc_sel.sv - next PC mux and alignment check
module next_pc_sel #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_target,
  input  logic            i_jump,
  input  logic            i_branch_taken,
  output logic [XLEN-1:0] o_next_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_misaligned
);
  logic [XLEN-1:0] w_target_even;

  // bit 0 is cleared so jalr targets land on a halfword boundary
  assign w_target_even = i_target & ~{{(XLEN-1){1'b0}}, 1'b1};
  assign o_pc_plus4    = i_pc + XLEN'(4);
  assign o_next_pc     = (i_jump || i_branch_taken) ? w_target_even : o_pc_plus4;
  assign o_misaligned  = o_next_pc[1];
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC holder, imem fetch handshake and instruction register
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  fetch_unit_if.master    imem,
  input  logic            exec_done,
  input  logic            branch_taken,
  input  logic            jump,
  input  logic [XLEN-1:0] target,
  output logic            inst_valid,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned,
  output logic [31:0]     instret
);
  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic            r_misaligned;
  logic [31:0]     r_instret;
  logic [XLEN-1:0] w_next_pc;
  logic            w_next_misaligned;
  logic            w_imem_req;
  logic            w_inst_valid;

  next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
    .i_pc           (r_pc),
    .i_target       (target),
    .i_jump         (jump),
    .i_branch_taken (branch_taken),
    .o_next_pc      (w_next_pc),
    .o_pc_plus4     (pc_plus4),
    .o_misaligned   (w_next_misaligned)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_imem_req   = 1'b0;
    w_inst_valid = 1'b0;
    case (r_state)
      S_BOOT: w_state_nxt = S_REQ;
      S_REQ: begin
        w_imem_req = 1'b1;
        if (imem.ack) w_state_nxt = S_VALID;
      end
      S_VALID: begin
        w_inst_valid = 1'b1;
        if (exec_done) w_state_nxt = w_next_misaligned ? S_HALT : S_REQ;
      end
      default: w_state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_PC;
      r_instr      <= XLEN'(NOP);
      r_misaligned <= 1'b0;
      r_instret    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_REQ && imem.ack) r_instr <= imem.rdata;
      // a misaligned target still retires the jump but freezes pc at it
      if (r_state == S_VALID && exec_done) begin
        r_instret <= r_instret + 32'd1;
        if (w_next_misaligned) r_misaligned <= 1'b1;
        else r_pc <= w_next_pc;
      end
    end
  end

  assign imem.req   = w_imem_req;
  assign imem.addr  = r_pc;
  assign inst_valid = w_inst_valid;
  assign instr      = r_instr;
  assign opcode     = r_instr[OPC_MSB:OPC_LSB];
  assign funct3     = r_instr[F3_MSB:F3_LSB];
  assign funct7     = r_instr[F7_MSB:F7_LSB];
  assign rd         = r_instr[RD_MSB:RD_LSB];
  assign rs1        = r_instr[RS1_MSB:RS1_LSB];
  assign rs2        = r_instr[RS2_MSB:RS2_LSB];
  assign pc         = r_pc;
  assign misaligned = r_misaligned;
  assign instret    = r_instret;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;
  logic        clk;
  logic        rst;
  logic        exec_done;
  logic        branch_taken;
  logic        jump;
  logic [31:0] target;
  logic        inst_valid;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misaligned;
  logic [31:0] instret;

  fetch_unit_if #(.XLEN(32)) imem_if ();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (imem_if),
    .exec_done    (exec_done),
    .branch_taken (branch_taken),
    .jump         (jump),
    .target       (target),
    .inst_valid   (inst_valid),
    .instr        (instr),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .rd           (rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .misaligned   (misaligned),
    .instret      (instret)
  );

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] addr;
  } exp_t;

  logic [31:0] exp_addr_q[$];
  exp_t        exp_instr_q[$];
  int          total = 0;
  int          bad   = 0;
  logic        prev_req   = 1'b0;
  logic        prev_valid = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic fail_unexpected(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got=%h want=none", name, act);
  endtask

  // monitor: pops expectations on each new fetch request and each new valid instruction
  always @(negedge clk) begin
    if (imem_if.req && !prev_req) begin
      if (exp_addr_q.size() == 0) fail_unexpected("unexpected_fetch", imem_if.addr);
      else check("fetch_addr", imem_if.addr, exp_addr_q.pop_front());
    end
    if (inst_valid && !prev_valid) begin
      if (exp_instr_q.size() == 0) fail_unexpected("unexpected_valid", instr);
      else begin
        exp_t e;
        e = exp_instr_q.pop_front();
        check("instr", instr, e.word);
        check("instr_pc", pc, e.addr);
        check("opcode_field", 32'(opcode), 32'(e.word[6:0]));
        check("rd_field", 32'(rd), 32'(e.word[11:7]));
      end
    end
    prev_req   <= imem_if.req;
    prev_valid <= inst_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exec(input logic j, input logic b, input logic [31:0] tgt,
                      input logic [31:0] nxt, input bit halt);
    exec_done    = 1'b1;
    jump         = j;
    branch_taken = b;
    target       = tgt;
    if (!halt) exp_addr_q.push_back(nxt);
    tick();
    exec_done    = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
    target       = 32'h0;
    if (!halt) begin
      check("req_latency", 32'(imem_if.req), 32'd1);
      check("next_addr", imem_if.addr, nxt);
    end
  endtask

  // exec-side inputs are toggled during the wait cycles; they must be ignored in S_REQ
  task automatic serve(input logic [31:0] word, input int dly, input logic [31:0] pc_exp);
    for (int i = 0; i < dly; i++) begin
      exec_done = 1'b1;
      jump      = 1'b1;
      target    = 32'h300;
      tick();
      check("req_hold", 32'(imem_if.req), 32'd1);
      check("addr_hold", imem_if.addr, pc_exp);
    end
    exec_done     = 1'b0;
    jump          = 1'b0;
    target        = 32'h0;
    imem_if.ack   = 1'b1;
    imem_if.rdata = word;
    exp_instr_q.push_back(exp_t'{word: word, addr: pc_exp});
    check("valid_before_ack", 32'(inst_valid), 32'd0);
    tick();
    imem_if.ack   = 1'b0;
    imem_if.rdata = 32'h0;
    check("valid_latency", 32'(inst_valid), 32'd1);
  endtask

  initial begin
    rst = 1'b1; exec_done = 1'b0; branch_taken = 1'b0; jump = 1'b0; target = 32'h0;
    imem_if.ack = 1'b0; imem_if.rdata = 32'h0;
    tick();
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_req", 32'(imem_if.req), 32'd0);
    check("rst_misaligned", 32'(misaligned), 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_pc", pc, 32'h0);
    rst = 1'b0;
    exp_addr_q.push_back(32'h0);
    tick();
    serve(32'h0050_0093, 2, 32'h0);
    check("addi_opcode", 32'(opcode), 32'h13);
    check("addi_rd", 32'(rd), 32'd1);
    check("addi_rs1", 32'(rs1), 32'd0);
    check("addi_funct3", 32'(funct3), 32'd0);
    check("addi_rs2", 32'(rs2), 32'd5);
    check("instret0", instret, 32'd0);

    exec(1'b1, 1'b0, 32'h10, 32'h10, 1'b0);
    check("instret1", instret, 32'd1);
    serve(32'h0020_81B3, 0, 32'h10);
    check("add_opcode", 32'(opcode), 32'h33);
    check("add_rd", 32'(rd), 32'd3);
    check("add_rs1", 32'(rs1), 32'd1);
    check("add_rs2", 32'(rs2), 32'd2);
    check("add_pc_plus4", pc_plus4, 32'h14);

    exec(1'b0, 1'b0, 32'h80, 32'h14, 1'b0);
    check("instret2", instret, 32'd2);
    serve(32'h4000_0033, 1, 32'h14);
    check("sub_funct7", 32'(funct7), 32'h20);

    exec(1'b0, 1'b1, 32'h40, 32'h40, 1'b0);
    serve(32'h0000_0013, 0, 32'h40);
    exec(1'b1, 1'b0, 32'h41, 32'h40, 1'b0);
    check("instret4", instret, 32'd4);
    serve(32'h0000_0013, 0, 32'h40);

    exec(1'b1, 1'b0, 32'h42, 32'h0, 1'b1);
    check("halt_misaligned", 32'(misaligned), 32'd1);
    check("halt_req", 32'(imem_if.req), 32'd0);
    check("halt_valid", 32'(inst_valid), 32'd0);
    check("halt_pc", pc, 32'h40);
    check("halt_instret", instret, 32'd5);
    for (int i = 0; i < 3; i++) begin
      imem_if.ack = 1'b1;
      exec_done   = 1'b1;
      tick();
      check("halt_req_stays", 32'(imem_if.req), 32'd0);
      check("halt_sticky", 32'(misaligned), 32'd1);
    end
    imem_if.ack = 1'b0;
    exec_done   = 1'b0;

    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_addr_q.push_back(32'h0);
    tick();
    serve(32'h0010_0113, 0, 32'h0);
    exec(1'b1, 1'b0, 32'h200, 32'h200, 1'b0);
    rst = 1'b1;
    imem_if.ack = 1'b1;
    imem_if.rdata = 32'hDEAD_BEEF;
    tick();
    check("midreq_rst_instr", instr, 32'h0000_0013);
    check("midreq_rst_req", 32'(imem_if.req), 32'd0);
    check("midreq_rst_pc", pc, 32'h0);
    check("midreq_rst_misaligned", 32'(misaligned), 32'd0);
    rst = 1'b0;
    imem_if.rdata = 32'hBAD0_0BAD;
    exp_addr_q.push_back(32'h0);
    tick();
    imem_if.ack = 1'b0;
    imem_if.rdata = 32'h0;
    check("boot_ack_ignored_instr", instr, 32'h0000_0013);
    check("boot_ack_ignored_valid", 32'(inst_valid), 32'd0);
    serve(32'h0010_0113, 1, 32'h0);
    check("addi2_rd", 32'(rd), 32'd2);

    exec(1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    serve(32'h0000_0013, 0, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", pc_plus4, 32'h0);
    exec(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("wrap_no_flag", 32'(misaligned), 32'd0);
    serve(32'h0000_0013, 0, 32'h0);
    exec(1'b0, 1'b0, 32'h0, 32'h4, 1'b0);
    serve(32'h0000_0013, 0, 32'h4);
    exec(1'b0, 1'b0, 32'h0, 32'h8, 1'b0);
    serve(32'h0000_0013, 0, 32'h8);
    check("instret_after_wrap", instret, 32'd4);

    tick();
    tick();
    check("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
    check("instr_q_empty", 32'(exp_instr_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
